threshold_calibrator: RTL
=========================

Name: threshold_calibrator

Overview:
- Automatic threshold calibrator that configures the position tracker's fringe-counter thresholds.
- Observes the same signed sample stream the tracker consumes for a window of 2^WINDOW_LOG2 valid samples and tracks signed min/max.
- Derives a hysteresis band centred on the signal midpoint and drives FC_lower_treshold / FC_upper_treshold.
- Sits between the AXI-Stream demodulator output and the position tracker's FC_* configuration inputs; runs once per start or continuously.

Parameters:
- AXIS_TDATA_WIDTH, 32: sample and threshold width; two's complement.
- WINDOW_LOG2, 10: acquisition window = 2^WINDOW_LOG2 valid samples; legal range 1..16.
- HYST_SHIFT, 2: half-band = span >> HYST_SHIFT; legal range 1..8.

Ports:
- SYS_aclk  in  1  system clock; all logic rising-edge.
- SYS_reset  in  1  synchronous, active-high reset.
- CFG_start  in  1  level-sampled; starts one calibration from IDLE.
- CFG_auto  in  1  1: re-acquire continuously after each APPLY.
- CFG_min_span  in  AXIS_TDATA_WIDTH  unsigned minimum accepted span (max-min).
- S_AXIS_tvalid  in  1  sample valid (monitor only, no tready).
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH  signed sample.
- FC_lower_treshold  out  AXIS_TDATA_WIDTH  signed lower threshold.
- FC_upper_treshold  out  AXIS_TDATA_WIDTH  signed upper threshold.
- FC_valid  out  1  thresholds have been written by at least one successful calibration.
- STAT_done  out  1  one-cycle pulse on each APPLY or REJECT.
- STAT_busy  out  1  high in ACQUIRE/COMPUTE/APPLY.
- STAT_error  out  1  sticky: last calibration rejected; cleared on next accepted start.

Behaviour:
- Reset (SYS_reset=1 at edge), regardless of state:
  - state=IDLE; counter, min and max cleared.
  - FC_lower_treshold=0, FC_upper_treshold=0; FC_valid=0, STAT_done=0, STAT_busy=0, STAT_error=0.
  - Any calibration in progress is discarded.
- IDLE:
  - CFG_start=1 -> ACQUIRE; sample counter := 0; STAT_error := 0.
- ACQUIRE:
  - Each cycle with S_AXIS_tvalid=1 accepts one sample.
  - First sample loads both min and max; later samples update them with signed compares.
  - tvalid=0 stalls; no timeout.
  - When the 2^WINDOW_LOG2-th sample is accepted -> COMPUTE on the next edge.
  - CFG_start ignored.
- COMPUTE (1 cycle), widths AXIS_TDATA_WIDTH+1:
  - span = max - min (unsigned, never negative).
  - mid = (max + min) >>> 1, arithmetic shift, rounds toward -inf.
  - delta = span >> HYST_SHIFT.
  - span < CFG_min_span (unsigned compare) -> REJECT; else -> APPLY.
- APPLY (1 cycle):
  - Outputs register FC_lower_treshold = mid - delta, FC_upper_treshold = mid + delta, truncated to AXIS_TDATA_WIDTH.
  - HYST_SHIFT>=1 guarantees both values lie within [min,max], so there is no overflow.
  - FC_valid := 1; STAT_done pulses in the cycle the new thresholds are visible.
- REJECT (1 cycle):
  - Thresholds and FC_valid unchanged; STAT_error := 1; STAT_done pulses.
- After APPLY/REJECT:
  - CFG_auto=1 -> ACQUIRE, with counter, min and max re-initialised.
  - Otherwise -> IDLE.
- Latency: thresholds update 2 edges after the edge accepting the last window sample.
- Both threshold outputs change on the same edge; no partial update is ever visible.
- Span=0 with CFG_min_span=0 is accepted; result is lower=upper=mid.
- CFG_auto deasserted mid-window: the current window completes, then the block returns to IDLE.

Test Plan:
- WINDOW_LOG2=2, HYST_SHIFT=2, CFG_min_span=0:
  - Samples 10,5,-15,15 -> span 30, mid 0, delta 7.
  - Lower=-7, upper=7, FC_valid=1, STAT_done pulses 2 edges after the 4th sample.
- Offset signal: samples 100,120,80,110 -> lower=90, upper=110.
  - With tvalid low for 3 cycles between samples, the same result arrives after the stall.
- CFG_min_span=50 with the offset samples above (span 40):
  - STAT_error=1, STAT_done pulse; thresholds and FC_valid keep their prior values.
  - Next start with CFG_min_span=0 clears STAT_error.
- Extremes:
  - Samples 0x7FFFFFFF, 0x80000000, 0, 0 -> mid=-1, delta=0x3FFFFFFF.
  - Lower=0xC0000000, upper=0x3FFFFFFE.
- CFG_auto=1, two windows (10,5,-15,15) then (-2,-4,-6,-8):
  - Thresholds -7/7, then -6/-4 (mid -5, delta 1).
  - STAT_busy stays high throughout both windows.
- SYS_reset asserted after 2 samples of a window:
  - Next edge: outputs 0, FC_valid=0, state IDLE.
  - A new start requires 4 fresh samples.

Source files
------------

// File: rtl/threshold_calibrator_if.sv
// Sample stream into the calibrator and the threshold bundle it drives.
// No timing of its own; pure wiring between demodulator, calibrator and tracker.
// The sample stream has no tready: the calibrator only monitors it.
interface threshold_calibrator_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic                        S_AXIS_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
    logic [AXIS_TDATA_WIDTH-1:0] FC_lower_treshold;
    logic [AXIS_TDATA_WIDTH-1:0] FC_upper_treshold;
    logic                        FC_valid;

    // Sample source / threshold consumer side.
    modport master (
        output S_AXIS_tvalid,
        output S_AXIS_tdata,
        input  FC_lower_treshold,
        input  FC_upper_treshold,
        input  FC_valid
    );

    // Calibrator side.
    modport slave (
        input  S_AXIS_tvalid,
        input  S_AXIS_tdata,
        output FC_lower_treshold,
        output FC_upper_treshold,
        output FC_valid
    );
endinterface

// File: rtl/threshold_calibrator.sv
// Measures signed min/max over 2^WINDOW_LOG2 samples and writes a hysteresis band around the midpoint.
// Thresholds update 2 edges after the edge accepting the last window sample.
// No backpressure: samples are observed only; tvalid low simply stalls the window.
module threshold_calibrator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int WINDOW_LOG2      = 10,
    parameter int HYST_SHIFT       = 2
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_reset,
    input  logic                        CFG_start,
    input  logic                        CFG_auto,
    input  logic [AXIS_TDATA_WIDTH-1:0] CFG_min_span,
    output logic                        STAT_done,
    output logic                        STAT_busy,
    output logic                        STAT_error,
    threshold_calibrator_if.slave       tc
);
    localparam int W = AXIS_TDATA_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQUIRE,
        S_COMPUTE,
        S_APPLY,
        S_REJECT
    } state_t;

    state_t state, next_state;

    logic [WINDOW_LOG2-1:0] cnt;
    logic signed [W-1:0]    min_q, max_q;
    logic [W-1:0]           lower_stg, upper_stg;

    logic                   sample_acc;
    logic                   last_sample;

    // One extra bit so span and sum of two extreme samples cannot overflow.
    logic signed [W:0]      max_x, min_x, sum;
    logic [W:0]             span;
    logic signed [W-1:0]    mid;
    logic [W-1:0]           delta;
    logic                   reject;

    assign sample_acc  = (state == S_ACQUIRE) && tc.S_AXIS_tvalid;
    assign last_sample = sample_acc && (cnt == '1);

    // Band arithmetic on the captured extremes; mid/delta always fit in W bits.
    always_comb begin
        max_x  = {max_q[W-1], max_q};
        min_x  = {min_q[W-1], min_q};
        span   = max_x - min_x;
        sum    = max_x + min_x;
        mid    = W'(sum >>> 1);
        delta  = W'(span >> HYST_SHIFT);
        reject = span < {1'b0, CFG_min_span};
    end

    // State register.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) state <= S_IDLE;
        else           state <= next_state;
    end

    // Next-state logic and busy indication.
    always_comb begin
        next_state = state;
        STAT_busy  = 1'b0;
        case (state)
            S_IDLE: begin
                if (CFG_start) next_state = S_ACQUIRE;
            end
            S_ACQUIRE: begin
                STAT_busy = 1'b1;
                if (last_sample) next_state = S_COMPUTE;
            end
            S_COMPUTE: begin
                STAT_busy  = 1'b1;
                next_state = reject ? S_REJECT : S_APPLY;
            end
            S_APPLY: begin
                STAT_busy  = 1'b1;
                next_state = CFG_auto ? S_ACQUIRE : S_IDLE;
            end
            S_REJECT: begin
                next_state = CFG_auto ? S_ACQUIRE : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Window accumulation, band staging and registered outputs.
    always_ff @(posedge SYS_aclk) begin
        if (SYS_reset) begin
            cnt                  <= '0;
            min_q                <= '0;
            max_q                <= '0;
            lower_stg            <= '0;
            upper_stg            <= '0;
            tc.FC_lower_treshold <= '0;
            tc.FC_upper_treshold <= '0;
            tc.FC_valid          <= 1'b0;
            STAT_done            <= 1'b0;
            STAT_error           <= 1'b0;
        end else begin
            STAT_done <= 1'b0;

            if (state == S_IDLE && CFG_start) begin
                cnt        <= '0;
                STAT_error <= 1'b0;
            end

            // First sample of a window seeds both extremes.
            if (sample_acc) begin
                cnt <= cnt + 1'b1;
                if (cnt == '0) begin
                    min_q <= tc.S_AXIS_tdata;
                    max_q <= tc.S_AXIS_tdata;
                end else begin
                    if ($signed(tc.S_AXIS_tdata) < min_q) min_q <= tc.S_AXIS_tdata;
                    if ($signed(tc.S_AXIS_tdata) > max_q) max_q <= tc.S_AXIS_tdata;
                end
            end

            // Staging keeps both thresholds landing on the same edge.
            if (state == S_COMPUTE) begin
                lower_stg <= mid - delta;
                upper_stg <= mid + delta;
            end

            if (state == S_APPLY) begin
                tc.FC_lower_treshold <= lower_stg;
                tc.FC_upper_treshold <= upper_stg;
                tc.FC_valid          <= 1'b1;
                STAT_done            <= 1'b1;
            end

            if (state == S_REJECT) begin
                STAT_error <= 1'b1;
                STAT_done  <= 1'b1;
            end

            if ((state == S_APPLY || state == S_REJECT) && CFG_auto) begin
                cnt <= '0;
            end
        end
    end
endmodule
